axis_mic_decimator: RTL and testbench

//  Consumes the 32-bit AXI-Stream words produced by i2s_receiver (one word per I2S channel slot, tlast=1 on the

---
 rtl/audio_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 33 +++
 rtl/axis_mic_decimator.sv | 107 ++++++++++
 tb/tb_axis_mic_decimator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions for the I2S/AXI-Stream front end.
//   I2S_WORD_W : width of one I2S slot word on the AXI-Stream link
//   i2s_ch_e   : channel encoding carried by tlast (0 = left, 1 = right)
//   clog2_min1 : $clog2 clamped to at least 1 bit, for counters that may need no range
//   is_pow2    : power-of-two test for elaboration checks
package audio_pkg;

  localparam int unsigned I2S_WORD_W = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data; wins over a same-cycle consume so valid stays high
//   load_data  : payload to capture
//   ready      : downstream ready
//   valid      : payload held
//   data       : held payload, zero when empty
module axis_out_reg #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/axis_mic_decimator.sv
// Channel-selecting boxcar decimator between i2s_receiver and the audio DSP.
// Picks one I2S channel (by tlast), averages DECIM signed samples and emits the
// top OUT_W bits of the average, with m_axis_tlast every FRAME_LEN outputs.
//   s_axis_aclk, s_axis_aresetn         : clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast    : I2S word stream (tlast = right channel)
//   m_axis_tvalid/tready/tdata/tlast    : decimated sample stream
//   overflow                            : sticky, input was stalled (audio lost)
module axis_mic_decimator
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned DECIM     = 4,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned CHANNEL   = 0,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [I2S_WORD_W-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [OUT_W-1:0]      m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  overflow
);

  localparam int unsigned LOG2D = $clog2(DECIM);
  localparam int unsigned ACC_W = SAMPLE_W + LOG2D;
  localparam int unsigned CNT_W = clog2_min1(DECIM);
  localparam int unsigned FRM_W = clog2_min1(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);
  localparam i2s_ch_e SEL_CH = (CHANNEL == 0) ? CH_LEFT : CH_RIGHT;

  if (!is_pow2(DECIM) || DECIM > 256) begin : g_bad_decim
    $error("DECIM must be a power of two in 1..256");
  end
  if (OUT_W > SAMPLE_W) begin : g_bad_out_w
    $error("OUT_W must not exceed SAMPLE_W");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("FRAME_LEN must be at least 1");
  end

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [SAMPLE_W-1:0] smp;
  logic        [SAMPLE_W-1:0] avg;
  logic        [CNT_W-1:0]    cnt;
  logic        [FRM_W-1:0]    frame_cnt;
  logic                       sel_accept;
  logic                       complete;
  logic                       unused_bits;

  assign smp        = s_axis_tdata[I2S_WORD_W-1 -: SAMPLE_W];
  assign acc_sum    = acc + ACC_W'(smp);
  // Sum of DECIM samples divided by DECIM always fits back into SAMPLE_W bits.
  assign avg        = SAMPLE_W'(acc_sum >>> LOG2D);
  assign sel_accept = s_axis_tvalid && s_axis_tready && (s_axis_tlast == logic'(SEL_CH));
  assign complete   = sel_accept && (cnt == CNT_LAST);

  // Only a completing word can collide with an unconsumed output.
  assign s_axis_tready = !(m_axis_tvalid && !m_axis_tready && (cnt == CNT_LAST));

  assign unused_bits = ^{s_axis_tdata, avg};

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      acc       <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
    end else if (sel_accept) begin
      if (complete) begin
        acc       <= '0;
        cnt       <= '0;
        frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      overflow <= 1'b0;
    end else if (s_axis_tvalid && !s_axis_tready) begin
      overflow <= 1'b1;
    end
  end

  axis_out_reg #(
    .W (OUT_W + 1)
  ) u_out_reg (
    .clk       (s_axis_aclk),
    .rst_n     (s_axis_aresetn),
    .load      (complete),
    .load_data ({(frame_cnt == FRM_LAST), avg[SAMPLE_W-1 -: OUT_W]}),
    .ready     (m_axis_tready),
    .valid     (m_axis_tvalid),
    .data      ({m_axis_tlast, m_axis_tdata})
  );

endmodule

// File: tb/tb_axis_mic_decimator.sv
module tb_axis_mic_decimator;

  localparam int SW = 24;
  localparam int OW = 16;
  localparam int D  = 4;
  localparam int FL = 4;
  localparam int FL1 = 3;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: left channel, DECIM=4, FRAME_LEN=4
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, m_valid, m_last, ovf;
  logic [15:0] m_data;

  // DUT 1: right channel, DECIM=1, FRAME_LEN=3
  logic        s_valid1 = 1'b0, s_last1 = 1'b0, m_ready1 = 1'b1;
  logic [31:0] s_data1 = '0;
  logic        s_ready1, m_valid1, m_last1, ovf1;
  logic [15:0] m_data1;

  axis_mic_decimator #(
    .SAMPLE_W (SW), .DECIM (D), .OUT_W (OW), .CHANNEL (0), .FRAME_LEN (FL)
  ) u_dut (
    .s_axis_aclk (clk), .s_axis_aresetn (rst_n),
    .s_axis_tvalid (s_valid), .s_axis_tready (s_ready),
    .s_axis_tdata (s_data), .s_axis_tlast (s_last),
    .m_axis_tvalid (m_valid), .m_axis_tready (m_ready),
    .m_axis_tdata (m_data), .m_axis_tlast (m_last),
    .overflow (ovf)
  );

  axis_mic_decimator #(
    .SAMPLE_W (SW), .DECIM (1), .OUT_W (OW), .CHANNEL (1), .FRAME_LEN (FL1)
  ) u_dut1 (
    .s_axis_aclk (clk), .s_axis_aresetn (rst_n),
    .s_axis_tvalid (s_valid1), .s_axis_tready (s_ready1),
    .s_axis_tdata (s_data1), .s_axis_tlast (s_last1),
    .m_axis_tvalid (m_valid1), .m_axis_tready (m_ready1),
    .m_axis_tdata (m_data1), .m_axis_tlast (m_last1),
    .overflow (ovf1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for DUT 0: group sums of selected samples, output queue.
  out_t   exp_q[$];
  longint grp_sum = 0;
  int     grp_n = 0;
  int     out_idx = 0;
  logic   exp_ovf = 1'b0;
  logic   obs_mv, obs_ml, obs_sr, obs_ovf;
  logic [15:0] obs_md;

  // Reference model for DUT 1.
  out_t exp1_q[$];
  int   out_idx1 = 0;
  logic obs_mv1;
  logic [15:0] obs_md1;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp1_q.delete();
    grp_sum  = 0;
    grp_n    = 0;
    out_idx  = 0;
    out_idx1 = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic step0(input logic v, input logic [31:0] d, input logic l, input logic mr);
    logic                exp_rdy;
    logic signed [23:0]  s24;
    longint              avg;
    out_t                o;
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; m_ready = mr;
    #1;
    obs_mv = m_valid; obs_md = m_data; obs_ml = m_last; obs_sr = s_ready; obs_ovf = ovf;
    exp_rdy = !(exp_q.size() != 0 && !mr && grp_n == D - 1);
    check_eq("m_valid", obs_mv, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("m_data", obs_md, exp_q[0].d);
      check_eq("m_last", obs_ml, exp_q[0].l);
    end
    check_eq("s_ready", obs_sr, exp_rdy);
    check_eq("overflow", obs_ovf, exp_ovf);
    if (v && !exp_rdy) exp_ovf = 1'b1;
    if (exp_q.size() != 0 && mr) void'(exp_q.pop_front());
    if (v && exp_rdy && l == 1'b0) begin
      s24 = d[31:8];
      grp_sum += longint'(s24);
      grp_n++;
      if (grp_n == D) begin
        avg = floor_div(grp_sum, D);
        avg = floor_div(avg, longint'(1) << (SW - OW));
        o.d = avg[15:0];
        o.l = (out_idx % FL == FL - 1);
        out_idx++;
        exp_q.push_back(o);
        grp_sum = 0;
        grp_n   = 0;
      end
    end
  endtask

  task automatic step1(input logic v, input logic [31:0] d, input logic l);
    out_t o;
    @(negedge clk);
    s_valid1 = v; s_data1 = d; s_last1 = l; m_ready1 = 1'b1;
    #1;
    obs_mv1 = m_valid1; obs_md1 = m_data1;
    check_eq("d1_m_valid", m_valid1, exp1_q.size() != 0);
    if (exp1_q.size() != 0) begin
      check_eq("d1_m_data", m_data1, exp1_q[0].d);
      check_eq("d1_m_last", m_last1, exp1_q[0].l);
      void'(exp1_q.pop_front());
    end
    check_eq("d1_s_ready", s_ready1, 1'b1);
    if (v && l) begin
      o.d = d[31:16];
      o.l = (out_idx1 % FL1 == FL1 - 1);
      out_idx1++;
      exp1_q.push_back(o);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; s_data = '0;
    s_valid1 = 1'b0; s_last1 = 1'b0; s_data1 = '0;
    #1;
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_data", m_data, 16'h0000);
    check_eq("rst_m_last", m_last, 1'b0);
    check_eq("rst_overflow", ovf, 1'b0);
    check_eq("rst_s_ready", s_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic lasts[$];

  initial begin
    // 1: alternating channels, only left samples averaged
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step0(1'b1, 32'h0001_0000, 1'b0, 1'b0);
      if (i == 3) check_eq("t1_no_early_out", obs_mv, 1'b0);
      step0(1'b1, 32'h7FFF_FF00, 1'b1, 1'b0);
    end
    check_eq("t1_valid", obs_mv, 1'b1);
    check_eq("t1_data", obs_md, 16'h0001);
    check_eq("t1_last", obs_ml, 1'b0);
    step0(1'b0, 32'h0, 1'b0, 1'b1);
    step0(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("t1_consumed", obs_mv, 1'b0);

    // 2: floor average and most-negative sample
    step0(1'b1, 32'h0000_0400, 1'b0, 1'b1);
    step0(1'b1, 32'h0000_0400, 1'b0, 1'b1);
    step0(1'b1, 32'h0000_0400, 1'b0, 1'b1);
    step0(1'b1, 32'hFFFF_F800, 1'b0, 1'b1);
    step0(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("t2_valid_a", obs_mv, 1'b1);
    check_eq("t2_data_a", obs_md, 16'h0000);
    for (int i = 0; i < 4; i++) step0(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    step0(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("t2_valid_b", obs_mv, 1'b1);
    check_eq("t2_data_b", obs_md, 16'h8000);

    // 3: frame boundary every FL outputs
    do_reset();
    lasts.delete();
    for (int i = 0; i < 22; i++) begin
      if (i < 20) step0(1'b1, {$urandom_range(0, 32'h00FF_FFFF), 8'h00}, 1'b0, 1'b1);
      else step0(1'b0, 32'h0, 1'b0, 1'b1);
      if (obs_mv) lasts.push_back(obs_ml);
    end
    check_eq("t3_count", lasts.size(), 5);
    if (lasts.size() == 5) begin
      check_eq("t3_last0", lasts[0], 1'b0);
      check_eq("t3_last2", lasts[2], 1'b0);
      check_eq("t3_last3", lasts[3], 1'b1);
      check_eq("t3_last4", lasts[4], 1'b0);
    end

    // 4: backpressure stall of the completing word
    do_reset();
    for (int i = 0; i < 4; i++) step0(1'b1, 32'h0001_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step0(1'b1, 32'h0003_0000, 1'b0, 1'b0);
      check_eq("t4_accept", obs_sr, 1'b1);
    end
    step0(1'b1, 32'h0003_0000, 1'b0, 1'b0);
    check_eq("t4_stall", obs_sr, 1'b0);
    step0(1'b1, 32'h0003_0000, 1'b0, 1'b1);
    check_eq("t4_overflow", obs_ovf, 1'b1);
    check_eq("t4_out1_data", obs_md, 16'h0001);
    check_eq("t4_ready_again", obs_sr, 1'b1);
    step0(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("t4_out2_valid", obs_mv, 1'b1);
    check_eq("t4_out2_data", obs_md, 16'h0003);

    // 5: reset mid-sum with a pending output
    do_reset();
    for (int i = 0; i < 6; i++) step0(1'b1, 32'h0050_0000, 1'b0, 1'b0);
    check_eq("t5_pending", obs_mv, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step0(1'b1, 32'h0002_0000, 1'b0, 1'b1);
    step0(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("t5_valid", obs_mv, 1'b1);
    check_eq("t5_data", obs_md, 16'h0002);

    // 6: right channel pass-through, back-to-back
    for (int i = 0; i < 6; i++) begin
      step1(1'b1, 32'hABCD_EF00, 1'b1);
      if (i > 0) begin
        check_eq("t6_valid", obs_mv1, 1'b1);
        check_eq("t6_data", obs_md1, 16'hABCD);
      end
    end
    step1(1'b1, 32'h1234_5600, 1'b0);
    step1(1'b1, 32'h1234_5600, 1'b0);
    check_eq("t6_left_ignored", obs_mv1, 1'b0);
    for (int i = 0; i < 60; i++) step1($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1));
    step1(1'b0, 32'h0, 1'b0);

    // Random traffic with random backpressure on DUT 0
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step0($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 3) != 0);
    end
    step0(1'b0, 32'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
